// File: rtl/usart_rx_drain_pkg.sv
// Shared USART register map, status bit positions, drain FSM encoding and FIFO word layout.
// Pure declarations; imported by the drain engine and its testbench.
package usart_pkg;
  localparam logic [11:0] UCSRnA_ADDR = 12'h0C0;
  localparam logic [11:0] UDRn_ADDR   = 12'h0C6;

  localparam int RXC = 7;
  localparam int FE  = 4;
  localparam int DOR = 3;
  localparam int UPE = 2;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    REQ     = 3'd1,
    RD_STAT = 3'd2,
    RD_DATA = 3'd3,
    COOL    = 3'd4
  } drain_state_t;

  typedef struct packed {
    logic       fe;
    logic       dor;
    logic       upe;
    logic [7:0] data;
  } rx_word_t;
endpackage

// File: rtl/usart_rx_drain_sync_fifo.sv
// Synchronous FIFO, head word visible combinationally; push to pop-visible is 1 cycle (no bypass).
// Push is ignored when full and pop is ignored when empty; producer must check full.
module sync_fifo #(
  parameter int WIDTH = 11,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_vld,
  input  logic [WIDTH-1:0]         push_dat,
  input  logic                     pop_vld,
  output logic [WIDTH-1:0]         head_dat,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign push_ok  = push_vld && !full;
  assign pop_ok   = pop_vld && !empty;
  // Stale entries are masked so the head reads zero while empty.
  assign head_dat = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= push_dat;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (push_ok && !pop_ok) begin
        count <= count + CW'(1);
      end else if (pop_ok && !push_ok) begin
        count <= count - CW'(1);
      end
    end
  end
endmodule

// File: rtl/usart_rx_drain.sv
// Drains USARTn on RxcIRQ: reads UCSRnA then UDRn, pushes {FE,DOR,UPE,data}; IRQ to push is 3 cycles.
// Stalls on bus_gnt and on a full FIFO; USART_RX_DRAIN_ERRDROP_EN drops FE/UPE words and counts them.
module usart_rx_drain
  import usart_pkg::*;
#(
  parameter int          DEPTH     = 8,
  parameter logic [11:0] BASE_ADDR = UCSRnA_ADDR
) (
  input  logic                   cp2,
  input  logic                   ireset,
  input  logic                   en,
  input  logic                   RxcIRQ,
  output logic                   bus_req,
  input  logic                   bus_gnt,
  output logic [11:0]            ram_Addr,
  output logic                   ramre,
  input  logic [7:0]             dbus_out,
  input  logic                   out_en,
  output logic                   rd_valid,
  output logic [10:0]            rd_data,
  input  logic                   rd_pop,
  output logic [$clog2(DEPTH):0] count,
  output logic                   bus_err
`ifdef USART_RX_DRAIN_ERRDROP_EN
  ,
  output logic [7:0]             drop_cnt
`endif
);
  drain_state_t state;
  logic [2:0]   stat_q;
  rx_word_t     push_word;
  logic         push_vld;
  logic         keep;
  logic         fifo_full;
  logic         fifo_empty;

  assign push_word = '{fe: stat_q[2], dor: stat_q[1], upe: stat_q[0], data: dbus_out};

`ifdef USART_RX_DRAIN_ERRDROP_EN
  assign keep = !(stat_q[2] || stat_q[0]);
`else
  assign keep = 1'b1;
`endif

  assign push_vld = (state == RD_DATA) && keep;
  assign rd_valid = !fifo_empty;

  always_ff @(posedge cp2) begin
    if (!ireset) begin
      state    <= IDLE;
      bus_req  <= 1'b0;
      ramre    <= 1'b0;
      ram_Addr <= '0;
      stat_q   <= '0;
      bus_err  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (en && RxcIRQ && !fifo_full) begin
            state   <= REQ;
            bus_req <= 1'b1;
          end
        end
        REQ: begin
          if (!en) begin
            state   <= IDLE;
            bus_req <= 1'b0;
          end else if (bus_gnt) begin
            state    <= RD_STAT;
            ramre    <= 1'b1;
            ram_Addr <= BASE_ADDR;
          end
        end
        RD_STAT: begin
          // Status must be captured before UDRn is read, which pops the USART buffer.
          stat_q   <= dbus_out[FE:UPE];
          state    <= RD_DATA;
          ram_Addr <= BASE_ADDR + 12'd6;
          if (!out_en) bus_err <= 1'b1;
        end
        RD_DATA: begin
          state    <= COOL;
          bus_req  <= 1'b0;
          ramre    <= 1'b0;
          ram_Addr <= '0;
          if (!out_en) bus_err <= 1'b1;
        end
        COOL: begin
          state <= IDLE;
        end
        default: begin
          state    <= IDLE;
          bus_req  <= 1'b0;
          ramre    <= 1'b0;
          ram_Addr <= '0;
        end
      endcase
    end
  end

`ifdef USART_RX_DRAIN_ERRDROP_EN
  always_ff @(posedge cp2) begin
    if (!ireset) begin
      drop_cnt <= '0;
    end else if ((state == RD_DATA) && !keep && (drop_cnt != 8'hFF)) begin
      drop_cnt <= drop_cnt + 8'd1;
    end
  end
`endif

  sync_fifo #(
    .WIDTH ($bits(rx_word_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (cp2),
    .rst_n    (ireset),
    .push_vld (push_vld),
    .push_dat (push_word),
    .pop_vld  (rd_pop),
    .head_dat (rd_data),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (count)
  );
endmodule

// File: tb/tb_usart_rx_drain.sv
// Bench for usart_rx_drain: USART modelled as a frame queue, FIFO modelled as an expected-word queue.
module tb_usart_rx_drain;
  localparam int          DEPTH  = 8;
  localparam logic [11:0] A_STAT = 12'h0C0;
  localparam logic [11:0] A_DATA = 12'h0C6;
`ifdef USART_RX_DRAIN_ERRDROP_EN
  localparam bit ERRDROP = 1'b1;
`else
  localparam bit ERRDROP = 1'b0;
`endif

  logic        cp2 = 1'b0;
  logic        ireset, en, RxcIRQ, bus_req, bus_gnt, ramre, out_en;
  logic        rd_valid, rd_pop, bus_err;
  logic [11:0] ram_Addr;
  logic [7:0]  dbus_out;
  logic [10:0] rd_data;
  logic [3:0]  count;
`ifdef USART_RX_DRAIN_ERRDROP_EN
  logic [7:0]  drop_cnt;
`endif

  int total = 0;
  int bad   = 0;

  logic [15:0] usart_q[$];   // pending frames {UCSRnA, UDRn}
  logic [10:0] exp_q[$];     // words the FIFO should hold
  logic        exp_err;
  int          exp_drop;
  logic        prev_stat;
  int          data_reads;

  always #5 cp2 = ~cp2;

  usart_rx_drain #(.DEPTH(DEPTH), .BASE_ADDR(A_STAT)) dut (
    .cp2      (cp2),
    .ireset   (ireset),
    .en       (en),
    .RxcIRQ   (RxcIRQ),
    .bus_req  (bus_req),
    .bus_gnt  (bus_gnt),
    .ram_Addr (ram_Addr),
    .ramre    (ramre),
    .dbus_out (dbus_out),
    .out_en   (out_en),
    .rd_valid (rd_valid),
    .rd_data  (rd_data),
    .rd_pop   (rd_pop),
    .count    (count),
    .bus_err  (bus_err)
`ifdef USART_RX_DRAIN_ERRDROP_EN
    ,
    .drop_cnt (drop_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic drive_usart();
    RxcIRQ   = (usart_q.size() != 0);
    dbus_out = 8'h00;
    if ((ramre === 1'b1) && (usart_q.size() != 0)) begin
      if (ram_Addr == A_STAT)      dbus_out = usart_q[0][15:8];
      else if (ram_Addr == A_DATA) dbus_out = usart_q[0][7:0];
    end
  endtask

  // One clock: predict from the bus activity before the edge, then check after it.
  task automatic cyc();
    logic        st_rd, dt_rd, popping, err_hit;
    logic [15:0] fr;
    drive_usart();
    st_rd   = (ramre === 1'b1) && (ram_Addr == A_STAT);
    dt_rd   = (ramre === 1'b1) && (ram_Addr == A_DATA) && (usart_q.size() != 0);
    err_hit = (ramre === 1'b1) && !out_en;
    popping = ireset && rd_pop && (exp_q.size() != 0);
    if (dt_rd) chk("stat_before_data", prev_stat, 1'b1);
    @(posedge cp2);
    #1;
    if (!ireset) begin
      exp_q.delete();
      exp_err  = 1'b0;
      exp_drop = 0;
    end else begin
      if (popping) void'(exp_q.pop_front());
      if (err_hit) exp_err = 1'b1;
      if (dt_rd) begin
        fr = usart_q[0];
        if (ERRDROP && (fr[12] || fr[10])) begin
          if (exp_drop < 255) exp_drop++;
        end else begin
          exp_q.push_back({fr[12], fr[11], fr[10], fr[7:0]});
        end
      end
    end
    if (dt_rd) begin
      void'(usart_q.pop_front());
      data_reads++;
    end
    prev_stat = st_rd;
    @(negedge cp2);
    drive_usart();
    chk("count", count, exp_q.size());
    chk("rd_valid", rd_valid, exp_q.size() != 0);
    if (exp_q.size() != 0) chk("rd_data", rd_data, exp_q[0]);
    chk("bus_err", bus_err, exp_err);
    if (ramre !== 1'b1) chk("addr_idle", ram_Addr, 12'h000);
`ifdef USART_RX_DRAIN_ERRDROP_EN
    chk("drop_cnt", drop_cnt, exp_drop);
`endif
  endtask

  initial begin
    int reads0;
    ireset = 1'b0; en = 1'b0; bus_gnt = 1'b0; out_en = 1'b1; rd_pop = 1'b0;
    RxcIRQ = 1'b0; dbus_out = 8'h00;
    exp_err = 1'b0; exp_drop = 0; prev_stat = 1'b0; data_reads = 0;

    // Reset state
    cyc(); cyc();
    chk("rst_bus_req", bus_req, 1'b0);
    chk("rst_ramre", ramre, 1'b0);
    chk("rst_addr", ram_Addr, 12'h000);
    chk("rst_rd_valid", rd_valid, 1'b0);
    chk("rst_rd_data", rd_data, 11'h000);
    chk("rst_count", count, 4'd0);
    chk("rst_bus_err", bus_err, 1'b0);
    ireset = 1'b1; en = 1'b1; bus_gnt = 1'b1;
    cyc();

    // Clean frame: status then data reads in consecutive cycles, word 3 cycles later
    usart_q.push_back({8'h80, 8'h65});
    cyc();
    chk("f1_req", bus_req, 1'b1);
    chk("f1_no_read_yet", ramre, 1'b0);
    cyc();
    chk("f1_stat_re", ramre, 1'b1);
    chk("f1_stat_addr", ram_Addr, A_STAT);
    cyc();
    chk("f1_data_re", ramre, 1'b1);
    chk("f1_data_addr", ram_Addr, A_DATA);
    cyc();
    chk("f1_valid", rd_valid, 1'b1);
    chk("f1_word", rd_data, 11'h065);
    chk("f1_count", count, 4'd1);
    rd_pop = 1'b1; cyc(); rd_pop = 1'b0;
    chk("f1_popped", count, 4'd0);

    // FE and UPE set
    reads0 = data_reads;
    usart_q.push_back({8'h94, 8'h67});
    repeat (5) cyc();
    chk("f2_udr_read", data_reads, reads0 + 1);
`ifdef USART_RX_DRAIN_ERRDROP_EN
    chk("f2_dropped_count", count, 4'd0);
    chk("f2_drop_cnt", drop_cnt, 8'd1);
`else
    chk("f2_word", rd_data, 11'h567);
    chk("f2_count", count, 4'd1);
    rd_pop = 1'b1; cyc(); rd_pop = 1'b0;
`endif

    // Fill past capacity with no pops
    for (int i = 0; i < DEPTH + 2; i++)
      usart_q.push_back({8'h80 | 8'($urandom_range(0, 1) << 3), 8'($urandom)});
    repeat (5 * (DEPTH + 2) + 10) cyc();
    chk("full_count", count, 4'd8);
    chk("full_no_req", bus_req, 1'b0);
    chk("full_left_in_usart", usart_q.size(), 2);
    repeat (4) cyc();
    chk("full_still_no_req", bus_req, 1'b0);
    rd_pop = 1'b1; cyc(); rd_pop = 1'b0;
    for (int i = 0; i < 2 && bus_req !== 1'b1; i++) cyc();
    chk("full_resume_req", bus_req, 1'b1);
    rd_pop = 1'b1;
    for (int i = 0; i < 100 && (usart_q.size() != 0 || exp_q.size() != 0); i++) cyc();
    rd_pop = 1'b0;
    cyc();
    chk("full_drained", count, 4'd0);

    // Randomised traffic
    for (int i = 0; i < 400; i++) begin
      if (($urandom_range(0, 7) == 0) && (usart_q.size() < 4))
        usart_q.push_back({8'h80 | (8'($urandom) & 8'h1C), 8'($urandom)});
      rd_pop  = ($urandom_range(0, 1) == 1);
      bus_gnt = ($urandom_range(0, 9) < 7);
      en      = ($urandom_range(0, 9) != 0);
      cyc();
    end
    en = 1'b1; bus_gnt = 1'b1; rd_pop = 1'b1;
    for (int i = 0; i < 200 && (usart_q.size() != 0 || exp_q.size() != 0); i++) cyc();
    rd_pop = 1'b0;
    cyc();
    chk("rand_drained_usart", usart_q.size(), 0);
    chk("rand_drained_fifo", count, 4'd0);

    // Grant held off for 10 cycles
    bus_gnt = 1'b0;
    usart_q.push_back({8'h80, 8'h11});
    cyc();
    chk("gnt_req", bus_req, 1'b1);
    for (int i = 0; i < 10; i++) begin
      cyc();
      chk("gnt_wait_ramre", ramre, 1'b0);
    end
    bus_gnt = 1'b1;
    cyc();
    chk("gnt_stat_re", ramre, 1'b1);
    chk("gnt_stat_addr", ram_Addr, A_STAT);
    repeat (4) cyc();
    chk("gnt_count", count, 4'd1);

    // out_en low during the reads
    out_en = 1'b0;
    usart_q.push_back({8'h88, 8'h3C});
    repeat (5) cyc();
    out_en = 1'b1;
    cyc();
    chk("oe_bus_err", bus_err, 1'b1);
    chk("oe_still_pushed", count, 4'd2);

    // Reset during the status read; frame is re-read afterwards
    usart_q.push_back({8'h80, 8'hA5});
    cyc();
    chk("rr_req", bus_req, 1'b1);
    cyc();
    chk("rr_stat_re", ramre, 1'b1);
    ireset = 1'b0;
    cyc();
    chk("rr_bus_req", bus_req, 1'b0);
    chk("rr_ramre", ramre, 1'b0);
    chk("rr_addr", ram_Addr, 12'h000);
    chk("rr_rd_valid", rd_valid, 1'b0);
    chk("rr_rd_data", rd_data, 11'h000);
    chk("rr_count", count, 4'd0);
    chk("rr_bus_err", bus_err, 1'b0);
    chk("rr_frame_kept", usart_q.size(), 1);
    ireset = 1'b1;
    for (int i = 0; i < 20 && usart_q.size() != 0; i++) cyc();
    cyc();
    chk("rr_reread_consumed", usart_q.size(), 0);
    chk("rr_reread_count", count, 4'd1);
    chk("rr_reread_word", rd_data, 11'h0A5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/usart_rx_drain.md
Name: usart_rx_drain

Overview:
- Autonomous receive-drain engine downstream of USARTn. It consumes RxcIRQ and reads UCSRnA, then UDRn, over the ram_Addr/ramre/dbus_out data-space port.
- Pushes {status, data} words into a local FIFO for a downstream consumer such as a packet parser.
- Removes per-byte CPU interrupt load at high baud rates.
- Time-shares the data bus with the CPU through a req/gnt pair.

Parameters:
- DEPTH, 8, FIFO entries; power of two, minimum 2.
- BASE_ADDR, 12'h0C0, UCSRnA address. UDRn is at BASE_ADDR+6.

Ports:
- cp2  in  1  system clock
- ireset  in  1  synchronous active-low reset
- en  in  1  drain enable; when low, no new bus transactions start
- RxcIRQ  in  1  receive-complete request from USARTn
- bus_req  out  1  request for the data-space bus
- bus_gnt  in  1  CPU-side grant; this block drives the bus only while granted
- ram_Addr  out  12  data-space address (valid while ramre=1, else 0)
- ramre  out  1  read strobe
- dbus_out  in  8  read data from USARTn, valid in the same cycle as ramre
- out_en  in  1  USARTn read-data valid qualifier
- rd_valid  out  1  FIFO non-empty
- rd_data  out  11  {FE, DOR, UPE, data[7:0]} at the FIFO head
- rd_pop  in  1  consumer pop; ignored when rd_valid=0
- count  out  log2(DEPTH)+1  current FIFO occupancy
- bus_err  out  1  sticky; set when out_en=0 during a drain read; cleared by reset only

Behaviour:
- Reset (ireset=0 at the cp2 rising edge) drives all outputs and state to 0:
  - state returns to IDLE
  - FIFO pointers are cleared
  - a read in progress is abandoned
  - the USART keeps the byte, and RxcIRQ re-triggers a full sequence after reset
- FSM states: IDLE, REQ, RD_STAT, RD_DATA, COOL.
  - IDLE: if en && RxcIRQ && count<DEPTH, go to REQ.
  - REQ: bus_req=1. When bus_gnt=1, go to RD_STAT. If en drops before the grant, go to IDLE.
  - RD_STAT: bus_req=1, ramre=1, ram_Addr=BASE_ADDR. Latch dbus_out[4:2] as FE/DOR/UPE (UCSRnA bit positions). Go to RD_DATA.
  - RD_DATA: bus_req=1, ramre=1, ram_Addr=BASE_ADDR+6. At this edge, push {FE, DOR, UPE, dbus_out} into the FIFO. Go to COOL.
  - COOL: one idle cycle, bus_req=0, to absorb RxcIRQ deassert latency. Go to IDLE.
- Status is always read before data, because UDRn read pops the USART buffer and status is only valid beforehand.
- Timing: RxcIRQ rise to FIFO push is 3 cycles when bus_gnt is already high. The pushed entry is visible on rd_valid the cycle after the push.
- bus_gnt is sampled only in REQ. Once granted, bus_req stays high through RD_DATA, and the grant must not be revoked mid-sequence. If bus_gnt drops during RD_STAT or RD_DATA, the sequence completes anyway.
- out_en=0 during RD_STAT or RD_DATA sets bus_err. The word is still pushed.
- FIFO full: no new sequence starts. The byte stays in the USART, whose own DOR reports any loss in a later status read. This block never overwrites or drops.
- Simultaneous push and pop:
  - count is unchanged
  - when the FIFO is empty, rd_valid is not combinationally bypassed; the word appears the next cycle
- Pointers wrap modulo DEPTH. count saturates structurally at DEPTH.
- Back-to-back frames: the minimum inter-sequence spacing is 5 cycles.

Optional Feature:
- Macro: USART_RX_DRAIN_ERRDROP_EN.
- Defined:
  - words with FE=1 or UPE=1 are not pushed (the UDRn read still happens)
  - an 8-bit saturating output drop_cnt increments per dropped word and resets to 0
- Undefined: every word is pushed with its flags, and there is no drop_cnt port.

Decomposition:
- Package usart_pkg holds:
  - address constants UCSRnA_ADDR=12'h0C0 and UDRn_ADDR=12'h0C6
  - bit indices RXC=7, FE=4, DOR=3, UPE=2
  - FSM state encoding
  - the rx_word struct: fe, dor, upe, data[7:0]
- One natural sub-module, sync_fifo: parameterised width and depth, with push/pop/count.

Test Plan:
- Granted bus, RxcIRQ pulse, UCSRnA=0x80, UDRn=0x65 -> ramre at addresses 0x0C0 then 0x0C6 in consecutive cycles; rd_data=11'h065 three cycles later; count=1.
- UCSRnA=0x94 (FE=1, UPE=1), UDRn=0x67, macro undefined -> rd_data=11'h567.
- Same stimulus as the previous case with the macro defined -> no push; drop_cnt=1; UDRn is still read.
- Hold RxcIRQ high for DEPTH+2 frames with no pops -> count stops at 8; bus_req stays 0; after one pop, the next sequence starts within 2 cycles.
- bus_gnt low for 10 cycles after bus_req rises -> ramre stays 0; reads start the cycle after the grant.
- ireset=0 during RD_STAT -> all outputs 0 next cycle; count=0; after reset, the same frame is re-read completely.
